// File: rtl/rf_write_arbiter.sv
// Arbitrates the single register-file write port between priority writeback (A) and a
// queued multi-cycle source (B), with a starvation guard and a pending-write lookup.
module rf_write_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_num,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_num,
  input  logic [DATA_W-1:0] b_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_wnum,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [ADDR_W-1:0] chk_num,
  output logic              chk_pend
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {PRIO_A = 1'b0, FORCE_B = 1'b1} state_t;

  state_t             state, state_nxt;
  logic [STV_W-1:0]   starve_cnt, starve_nxt;

  logic [ADDR_W-1:0]  fifo_num  [FIFO_DEPTH];
  logic [DATA_W-1:0]  fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [CNT_W-1:0]   count;

  logic               head_vld;
  logic               push, pop;
  logic               grant_a, grant_b;

  logic               wr_vld_p0;
  logic [ADDR_W-1:0]  wr_num_p0;
  logic [DATA_W-1:0]  wr_data_p0;

  logic               fifo_hit;
  logic [PTR_W-1:0]   scan_idx;

  // Writes to r0 are architecturally discarded, so they never become real writes.
  function automatic logic is_real_write(input logic [ADDR_W-1:0] num);
    return num != '0;
  endfunction

  // b_ready looks only at the occupancy at the start of the cycle, so a full
  // queue refuses a push even when the head leaves in the same cycle.
  assign head_vld = (count != '0);
  assign b_ready  = (count != CNT_W'(FIFO_DEPTH));
  assign push     = b_valid & b_ready;
  assign pop      = grant_b;

  always_comb begin
    state_nxt  = state;
    starve_nxt = starve_cnt;
    a_ready    = 1'b0;
    grant_a    = 1'b0;
    grant_b    = 1'b0;
    case (state)
      PRIO_A: begin
        a_ready = 1'b1;
        if (a_valid) begin
          grant_a = 1'b1;
          if (head_vld) begin
            starve_nxt = starve_cnt + STV_W'(1);
            if (starve_cnt == STV_W'(STARVE_LIMIT - 1)) state_nxt = FORCE_B;
          end
        end else if (head_vld) begin
          grant_b    = 1'b1;
          starve_nxt = '0;
        end
      end
      FORCE_B: begin
        grant_b    = head_vld;
        starve_nxt = '0;
        state_nxt  = PRIO_A;
      end
      default: begin
        state_nxt  = PRIO_A;
        starve_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= PRIO_A;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue storage is pure data; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_num[wr_ptr]  <= b_num;
      fifo_data[wr_ptr] <= b_data;
    end
  end

  // ---- stage p0: select the granted write ----
  assign wr_vld_p0  = grant_a | grant_b;
  assign wr_num_p0  = grant_a ? a_num  : fifo_num[rd_ptr];
  assign wr_data_p0 = grant_a ? a_data : fifo_data[rd_ptr];

  // ---- stage p1: registered write port ----
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_wnum  <= '0;
      rf_wdata <= '0;
    end else if (wr_vld_p0) begin
      rf_we    <= is_real_write(wr_num_p0);
      rf_wnum  <= wr_num_p0;
      rf_wdata <= wr_data_p0;
    end else begin
      rf_we    <= 1'b0;
    end
  end

  always_comb begin
    fifo_hit = 1'b0;
    scan_idx = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      scan_idx = rd_ptr + PTR_W'(i);
      if ((CNT_W'(i) < count) && (fifo_num[scan_idx] == chk_num)) fifo_hit = 1'b1;
    end
  end

  assign chk_pend = is_real_write(chk_num) &&
                    (fifo_hit || (rf_we && (rf_wnum == chk_num)));

endmodule
